// File: rtl/mips_cpu_regfile_mp.sv
// Multi-ported register file with two write ports, load-pending scoreboard and pending count.
// Optional same-cycle write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module mips_cpu_regfile_mp #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_READ   = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           wa_enable,
    input  logic [ADDR_WIDTH-1:0]          wa_reg,
    input  logic [DATA_WIDTH-1:0]          wa_data,
    input  logic                           wb_enable,
    input  logic [ADDR_WIDTH-1:0]          wb_reg,
    input  logic [DATA_WIDTH-1:0]          wb_data,
    input  logic                           mark_enable,
    input  logic [ADDR_WIDTH-1:0]          mark_reg,
    input  logic [NUM_READ*ADDR_WIDTH-1:0] read_reg,
    output logic [NUM_READ*DATA_WIDTH-1:0] read_data,
    output logic [NUM_READ-1:0]            read_busy,
    output logic [DATA_WIDTH-1:0]          read_data_v0,
    output logic [ADDR_WIDTH:0]            pending_count
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs_q [DEPTH];
    logic [DATA_WIDTH-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0]      pending_q;
    logic [DEPTH-1:0]      pending_d;
    logic [ADDR_WIDTH:0]   count_q;
    logic [ADDR_WIDTH:0]   count_d;
    logic                  cnt_set;
    logic                  cnt_clr;

    always_comb begin
        for (int r = 0; r < DEPTH; r++) begin
            regs_d[r] = regs_q[r];
        end
        for (int r = 1; r < DEPTH; r++) begin
            if (wa_enable && wa_reg == ADDR_WIDTH'(r)) begin
                regs_d[r] = wa_data;
            end else if (wb_enable && wb_reg == ADDR_WIDTH'(r)) begin
                regs_d[r] = wb_data;
            end
        end
        regs_d[0] = '0;
    end

    // A mark in the same cycle as a load return keeps the register pending.
    always_comb begin
        pending_d = pending_q;
        if (wb_enable) begin
            pending_d[wb_reg] = 1'b0;
        end
        if (mark_enable) begin
            pending_d[mark_reg] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_comb begin
        cnt_set = mark_enable && (mark_reg != '0) && !pending_q[mark_reg];
        cnt_clr = wb_enable && (wb_reg != '0) && pending_q[wb_reg]
                  && !(mark_enable && mark_reg == wb_reg);
        count_d = count_q;
        unique case ({cnt_set, cnt_clr})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < DEPTH; r++) begin
                regs_q[r] <= '0;
            end
            pending_q <= '0;
            count_q   <= '0;
        end else begin
            for (int r = 0; r < DEPTH; r++) begin
                regs_q[r] <= regs_d[r];
            end
            pending_q <= pending_d;
            count_q   <= count_d;
        end
    end

    always_comb begin
        logic [ADDR_WIDTH-1:0] idx;
        logic [DATA_WIDTH-1:0] rd;
        logic                  rb;
        read_data = '0;
        read_busy = '0;
        idx       = '0;
        rd        = '0;
        rb        = 1'b0;
        for (int p = 0; p < NUM_READ; p++) begin
            idx = read_reg[p*ADDR_WIDTH +: ADDR_WIDTH];
            rd  = regs_q[idx];
            rb  = pending_q[idx];
`ifdef REGFILE_BYPASS_EN
            if (idx != '0) begin
                if (wa_enable && wa_reg == idx) begin
                    rd = wa_data;
                end else if (wb_enable && wb_reg == idx) begin
                    rd = wb_data;
                end
                if (wb_enable && wb_reg == idx
                    && !(mark_enable && mark_reg == idx)) begin
                    rb = 1'b0;
                end
            end
`endif
            read_data[p*DATA_WIDTH +: DATA_WIDTH] = rd;
            read_busy[p] = rb;
        end
    end

    always_comb begin
        read_data_v0 = regs_q[2];
`ifdef REGFILE_BYPASS_EN
        if (wa_enable && wa_reg == ADDR_WIDTH'(2)) begin
            read_data_v0 = wa_data;
        end else if (wb_enable && wb_reg == ADDR_WIDTH'(2)) begin
            read_data_v0 = wb_data;
        end
`endif
    end

    assign pending_count = count_q;

endmodule

// File: tb/tb_mips_cpu_regfile_mp.sv
// Self-checking bench for mips_cpu_regfile_mp: reference model plus directed vectors.
// Honours REGFILE_BYPASS_EN in both the model and the literal expectations.
module tb_mips_cpu_regfile_mp;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;
    localparam int DEPTH = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          wa_enable, wb_enable, mark_enable;
    logic [AW-1:0] wa_reg, wb_reg, mark_reg;
    logic [DW-1:0] wa_data, wb_data;
    logic [NR*AW-1:0] read_reg;
    logic [NR*DW-1:0] read_data;
    logic [NR-1:0]    read_busy;
    logic [DW-1:0]    read_data_v0;
    logic [AW:0]      pending_count;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] mreg [DEPTH];
    bit   [DEPTH-1:0] mpend;
    bit            started = 0;

    mips_cpu_regfile_mp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ(NR)) dut (
        .clk(clk), .reset(reset),
        .wa_enable(wa_enable), .wa_reg(wa_reg), .wa_data(wa_data),
        .wb_enable(wb_enable), .wb_reg(wb_reg), .wb_data(wb_data),
        .mark_enable(mark_enable), .mark_reg(mark_reg),
        .read_reg(read_reg), .read_data(read_data), .read_busy(read_busy),
        .read_data_v0(read_data_v0), .pending_count(pending_count)
    );

    always #5 clk = ~clk;

    // Reference model: architectural state, updated in plain sequential order.
    always @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < DEPTH; r++) mreg[r] = '0;
            mpend = '0;
        end else begin
            if (wb_enable && wb_reg != 0) begin
                mreg[wb_reg] = wb_data;
                mpend[wb_reg] = 1'b0;
            end
            if (wa_enable && wa_reg != 0) mreg[wa_reg] = wa_data;
            if (mark_enable && mark_reg != 0) mpend[mark_reg] = 1'b1;
        end
        started = 1;
    end

    function automatic logic [DW-1:0] exp_data(input logic [AW-1:0] i);
        logic [DW-1:0] v;
        v = mreg[i];
`ifdef REGFILE_BYPASS_EN
        if (i != 0 && wb_enable && wb_reg == i) v = wb_data;
        if (i != 0 && wa_enable && wa_reg == i) v = wa_data;
`endif
        return v;
    endfunction

    function automatic logic exp_busy(input logic [AW-1:0] i);
        logic b;
        b = mpend[i];
`ifdef REGFILE_BYPASS_EN
        if (i != 0 && wb_enable && wb_reg == i
            && !(mark_enable && mark_reg == i)) b = 1'b0;
`endif
        return b;
    endfunction

    always @(negedge clk) begin
        if (started) begin
            for (int p = 0; p < NR; p++) begin
                logic [AW-1:0] ix;
                ix = read_reg[p*AW +: AW];
                checks++;
                if (read_data[p*DW +: DW] !== exp_data(ix)) begin
                    errors++;
                    $display("FAIL model_rdata p%0d idx%0d: got %h want %h",
                             p, ix, read_data[p*DW +: DW], exp_data(ix));
                end
                checks++;
                if (read_busy[p] !== exp_busy(ix)) begin
                    errors++;
                    $display("FAIL model_busy p%0d idx%0d: got %b want %b",
                             p, ix, read_busy[p], exp_busy(ix));
                end
            end
            checks++;
            if (read_data_v0 !== exp_data(AW'(2))) begin
                errors++;
                $display("FAIL model_v0: got %h want %h",
                         read_data_v0, exp_data(AW'(2)));
            end
            checks++;
            if (pending_count !== ($countones(mpend) & 6'h3f)) begin
                errors++;
                $display("FAIL model_count: got %0d want %0d",
                         pending_count, $countones(mpend));
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic idle();
        wa_enable = 0; wb_enable = 0; mark_enable = 0;
        wa_reg = 0; wb_reg = 0; mark_reg = 0;
        wa_data = 0; wb_data = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic rd(input int p0, input int p1);
        read_reg = {AW'(p1), AW'(p0)};
    endtask

    initial begin
        idle();
        read_reg = '0;
        reset = 1;
        wa_enable = 1; wa_reg = 4; wa_data = 32'h1111_1111;
        tick();
        idle();
        tick();
        reset = 0;

        // Sweep every index on both ports after reset.
        for (int i = 0; i < DEPTH; i++) begin
            rd(i, DEPTH - 1 - i);
            #1;
            chk("rst_rdata", {32'h0, read_data[31:0]}, 64'h0);
            chk("rst_busy", {62'h0, read_busy}, 64'h0);
            tick();
        end
        chk("rst_count", {58'h0, pending_count}, 64'h0);
        chk("rst_v0", {32'h0, read_data_v0}, 64'h0);

        // Port A wins a same-register collision.
        wa_enable = 1; wa_reg = 5; wa_data = 32'hDEAD_BEEF;
        wb_enable = 1; wb_reg = 5; wb_data = 32'h1234_5678;
        tick();
        idle();
        rd(5, 0);
        #1;
        chk("collide_A", {32'h0, read_data[31:0]}, 64'hDEAD_BEEF);

        // Different targets both complete.
        wa_enable = 1; wa_reg = 11; wa_data = 32'hAAAA_0011;
        wb_enable = 1; wb_reg = 12; wb_data = 32'hBBBB_0012;
        tick();
        idle();
        rd(11, 12);
        #1;
        chk("dual_a", {32'h0, read_data[31:0]}, 64'hAAAA_0011);
        chk("dual_b", {32'h0, read_data[63:32]}, 64'hBBBB_0012);

        // Index 0 ignores writes and marks.
        wa_enable = 1; wa_reg = 0; wa_data = 32'hFFFF_FFFF;
        mark_enable = 1; mark_reg = 0;
        tick();
        idle();
        rd(0, 0);
        #1;
        chk("r0_data", {32'h0, read_data[31:0]}, 64'h0);
        chk("r0_count", {58'h0, pending_count}, 64'h0);

        // Mark, re-mark, clear, and mark-beats-clear.
        mark_enable = 1; mark_reg = 7; tick();
        mark_reg = 9; tick();
        mark_reg = 7; tick();
        idle();
        chk("mark_cnt2", {58'h0, pending_count}, 64'd2);
        wb_enable = 1; wb_reg = 7; wb_data = 32'h0000_0077;
        tick();
        idle();
        rd(7, 9);
        #1;
        chk("clr_cnt1", {58'h0, pending_count}, 64'd1);
        chk("clr_busy7", {63'h0, read_busy[0]}, 64'd0);
        chk("busy9", {63'h0, read_busy[1]}, 64'd1);
        mark_enable = 1; mark_reg = 9;
        wb_enable = 1; wb_reg = 9; wb_data = 32'h0000_0099;
        tick();
        idle();
        rd(9, 7);
        #1;
        chk("mk_win_cnt", {58'h0, pending_count}, 64'd1);
        chk("mk_win_busy", {63'h0, read_busy[0]}, 64'd1);
        chk("mk_win_data", {32'h0, read_data[31:0]}, 64'h99);

        // Same-cycle visibility of a write to register 2.
        rd(0, 2);
        wa_enable = 1; wa_reg = 2; wa_data = 32'hA5A5_A5A5;
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("byp_port1", {32'h0, read_data[63:32]}, 64'hA5A5_A5A5);
        chk("byp_v0", {32'h0, read_data_v0}, 64'hA5A5_A5A5);
`else
        chk("nobyp_port1", {32'h0, read_data[63:32]}, 64'h0);
        chk("nobyp_v0", {32'h0, read_data_v0}, 64'h0);
`endif
        tick();
        idle();
        chk("wr2_port1", {32'h0, read_data[63:32]}, 64'hA5A5_A5A5);
        chk("wr2_v0", {32'h0, read_data_v0}, 64'hA5A5_A5A5);

        // Fill every pending bit, then drain through port B.
        for (int r = 1; r < DEPTH; r++) begin
            mark_enable = 1; mark_reg = AW'(r);
            tick();
        end
        idle();
        chk("cnt_full", {58'h0, pending_count}, 64'd31);
        for (int r = 1; r < DEPTH; r++) begin
            wb_enable = 1; wb_reg = AW'(r); wb_data = 32'h100 + r;
            tick();
        end
        idle();
        chk("cnt_drain", {58'h0, pending_count}, 64'd0);
        wb_enable = 1; wb_reg = 13; wb_data = 32'h13;
        tick();
        idle();
        chk("cnt_no_underflow", {58'h0, pending_count}, 64'd0);

        // Reset wins over same-cycle write and mark.
        mark_enable = 1; mark_reg = 3; tick();
        idle();
        wb_enable = 1; wb_reg = 4; wb_data = 32'h44;
        tick();
        idle();
        chk("pre_rst_cnt", {58'h0, pending_count}, 64'd1);
        reset = 1;
        wa_enable = 1; wa_reg = 6; wa_data = 32'h66;
        mark_enable = 1; mark_reg = 10;
        tick();
        reset = 0;
        idle();
        rd(6, 4);
        #1;
        chk("rst2_cnt", {58'h0, pending_count}, 64'd0);
        chk("rst2_r6", {32'h0, read_data[31:0]}, 64'h0);
        chk("rst2_r4", {32'h0, read_data[63:32]}, 64'h0);
        for (int i = 0; i < DEPTH; i++) begin
            rd(i, (i + 3) % DEPTH);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mips_cpu_regfile_mp.md
MIPS_CPU_REGFILE_MP -- requirements
Module: mips_cpu_regfile_mp

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of every register and data port.
REQ-002 Parameter ADDR_WIDTH, default 5: register index width; depth = 2**ADDR_WIDTH.
REQ-003 Parameter NUM_READ, default 2: number of independent read ports, range 1..4.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 wa_enable  input  1  write port A (ALU writeback) enable.
REQ-007 wa_reg  input  ADDR_WIDTH  write port A destination index.
REQ-008 wa_data  input  DATA_WIDTH  write port A data.
REQ-009 wb_enable  input  1  write port B (load writeback) enable.
REQ-010 wb_reg  input  ADDR_WIDTH  write port B destination index.
REQ-011 wb_data  input  DATA_WIDTH  write port B data.
REQ-012 mark_enable  input  1  marks a register pending, i.e. awaiting an outstanding load.
REQ-013 mark_reg  input  ADDR_WIDTH  index to mark pending.
REQ-014 read_reg  input  NUM_READ*ADDR_WIDTH  packed read indices; port i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
REQ-015 read_data  output  NUM_READ*DATA_WIDTH  packed read data, same packing rule.
REQ-016 read_busy  output  NUM_READ  per-port flag: the indexed register is pending.
REQ-017 read_data_v0  output  DATA_WIDTH  contents of register 2.
REQ-018 pending_count  output  ADDR_WIDTH+1  number of registers currently pending.

Function
REQ-019 Register 0 SHALL always read 0; writes and marks to index 0 SHALL be ignored.
REQ-020 Reads SHALL be combinational from current register state; writes take effect at the next rising edge.
REQ-021 When both write ports target the same non-zero register in one cycle, port A data SHALL be stored.
REQ-022 When the write ports target different registers, both writes SHALL complete in the same cycle.
REQ-023 Each register SHALL have one pending bit; mark_enable SHALL set pending[mark_reg] at the next edge.
REQ-024 A port B write SHALL clear pending[wb_reg] at the next edge; port A writes SHALL NOT change pending state.
REQ-025 When a mark and a port B clear hit the same register in one cycle, the register SHALL end pending; the mark takes precedence.
REQ-026 read_busy[i] SHALL equal pending[read_reg_i]; it SHALL be 0 for index 0.
REQ-027 pending_count SHALL track the population of pending bits exactly, changing by -1, 0 or +1 per cycle; marking an already-pending register SHALL leave the count unchanged.
REQ-028 pending_count SHALL NOT exceed 2**ADDR_WIDTH-1, and SHALL NOT underflow on a clear of a non-pending register.

Reset
REQ-029 While reset is high at a rising edge, all registers SHALL become 0 and all pending bits SHALL become 0.
REQ-030 After reset: read_data all 0, read_busy all 0, read_data_v0 = 0, pending_count = 0.
REQ-031 Reset SHALL override any write or mark presented in the same cycle.

Configuration
REQ-032 Macro REGFILE_BYPASS_EN SHALL control write-to-read forwarding.
REQ-033 With REGFILE_BYPASS_EN defined, a read of a non-zero index being written in the same cycle SHALL return that cycle's write data, using the REQ-021 priority; a same-cycle port B write to that index SHALL force read_busy to 0 unless a same-cycle mark targets the index; read_data_v0 SHALL forward in the same way.
REQ-034 Without REGFILE_BYPASS_EN, reads SHALL return the stored value only; new data SHALL be visible the cycle after the write.

Verification
REQ-035 Reset, then read all indices on every port -> all read_data = 0, read_busy = 0, pending_count = 0.
REQ-036 wa_reg=5, wa_data=0xDEADBEEF and wb_reg=5, wb_data=0x12345678 in one cycle -> next cycle register 5 reads 0xDEADBEEF.
REQ-037 wa_reg=0, wa_data=0xFFFFFFFF -> register 0 still reads 0; mark_reg=0 -> pending_count stays 0.
REQ-038 mark 7, then 9, then 7 again -> pending_count = 2; wb write to 7 -> count = 1, read_busy for 7 = 0; mark 9 together with a wb write to 9 -> 9 stays pending, count = 1.
REQ-039 Bypass build: wa_reg=2, wa_data=0xA5A5A5A5, read_reg port 1 = 2 in the same cycle -> read_data port 1 and read_data_v0 = 0xA5A5A5A5 that cycle; non-bypass build -> old value that cycle, 0xA5A5A5A5 the next.
REQ-040 Mark 3, write register 4 on port B, then assert reset with wa_enable high -> after the edge all registers, pending bits and pending_count = 0.
